rix_fb_swap_ctrl: RTL and testbench
===================================

RIX_FB_SWAP_CTRL -- requirements
Module: rix_fb_swap_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of fb_addr and render_fb_addr.
REQ-002 SHALL have parameter FB_SIZE_IN_PIXEL_LG, default 20, width of the size fields.
REQ-003 SHALL have parameter NUM_BUFFERS, default 3, number of ring buffers; legal range 2..4.
REQ-004 SHALL have parameters FB_BASE_ADDR, default 0, and FB_STRIDE, default 32'h0010_0000; buffer i address = FB_BASE_ADDR + i*FB_STRIDE.
REQ-005 SHALL have port aclk, in, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-007 SHALL have ports swap_req_valid in 1, swap_req_ready out 1, swap_req_vsync in 1 and swap_req_size in FB_SIZE_IN_PIXEL_LG, forming the renderer swap request.
REQ-008 SHALL have port render_fb_addr, out, ADDR_WIDTH, the buffer the renderer draws into.
REQ-009 SHALL have ports swap_fb out 1, swap_fb_enable_vsync out 1, fb_addr out ADDR_WIDTH, fb_size out FB_SIZE_IN_PIXEL_LG and fb_swapped in 1, forming the display handshake.
REQ-010 SHALL have port swap_timeout, out, 1, sticky watchdog flag.

Function
REQ-011 SHALL track disp_idx (displayed buffer), queue count q (0..NUM_BUFFERS-1) and rend_idx = (disp_idx+1+q) mod NUM_BUFFERS.
REQ-012 SHALL drive swap_req_ready = (q < NUM_BUFFERS-1); acceptance occurs when swap_req_valid and swap_req_ready are both high at a clock edge.
REQ-013 On acceptance, SHALL store swap_req_vsync and swap_req_size against rend_idx, increment q and advance rend_idx.
REQ-014 SHALL drive render_fb_addr combinationally from rend_idx; the address is valid only while swap_req_ready is high.
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-016 In IDLE with q>0, SHALL transition to ISSUE on the next edge; with q=0 it SHALL stay in IDLE.
REQ-017 In ISSUE, SHALL drive swap_fb high for exactly one cycle, with fb_addr and fb_size taken from buffer (disp_idx+1) mod NUM_BUFFERS and swap_fb_enable_vsync from that buffer's stored vsync bit, then SHALL go to WAIT.
REQ-018 SHALL hold fb_addr, fb_size and swap_fb_enable_vsync stable from ISSUE until the next ISSUE.
REQ-019 In WAIT, on fb_swapped high, SHALL increment disp_idx mod NUM_BUFFERS, decrement q and return to IDLE.
REQ-020 SHALL ignore fb_swapped outside WAIT.
REQ-021 When acceptance and fb_swapped completion occur on the same edge, q SHALL remain unchanged while both indices advance.
REQ-022 disp_idx and rend_idx arithmetic SHALL wrap modulo NUM_BUFFERS for non-power-of-two values.

Reset
REQ-023 While reset is high, SHALL hold disp_idx=0, q=0, rend_idx=1, state IDLE, swap_fb=0, swap_fb_enable_vsync=0, fb_addr=FB_BASE_ADDR, fb_size=0 and swap_timeout=0.
REQ-024 Assertion of reset mid-operation SHALL discard all queued swaps and any outstanding WAIT without issuing further swap_fb pulses.

Configuration
REQ-025 SHALL provide macro RIX_FB_SWAP_WATCHDOG_EN.
REQ-026 With RIX_FB_SWAP_WATCHDOG_EN defined, a 24-bit counter SHALL run in WAIT; after 2^24 cycles without fb_swapped it SHALL complete the swap as in REQ-019 and set swap_timeout (cleared only by reset).
REQ-027 With RIX_FB_SWAP_WATCHDOG_EN undefined, the counter SHALL be absent, WAIT SHALL last indefinitely and swap_timeout SHALL be tied 0.

Verification
REQ-028 Reset, N=3 -> swap_req_ready=1, render_fb_addr=FB_BASE_ADDR+FB_STRIDE, swap_fb=0.
REQ-029 One request (vsync=1, size=76800), fb_swapped 5 cycles later -> a single swap_fb pulse one cycle after acceptance with fb_addr=base+stride, fb_size=76800 and enable_vsync=1; then disp_idx=1 and render_fb_addr=base+2*stride.
REQ-030 N=2, two back-to-back requests with fb_swapped held low -> the second request is accepted only after fb_swapped, and ready is low in between.
REQ-031 N=3, fb_swapped strobed in the same cycle as a new acceptance -> q unchanged, no lost or duplicate swap_fb pulse, and the index wraps 2->0.
REQ-032 Reset asserted during WAIT with q=2 -> after release, REQ-023 values hold and no swap_fb pulse occurs.
REQ-033 With RIX_FB_SWAP_WATCHDOG_EN defined and fb_swapped never asserted -> completion occurs after 2^24 cycles and swap_timeout=1.

Source files
------------

// File: rtl/rix_fb_swap_ctrl.sv
// Framebuffer ring swap controller: queues renderer swap requests and issues them to the display one at a time.
// Optional watchdog on the display handshake is enabled with `define RIX_FB_SWAP_WATCHDOG_EN.
module rix_fb_swap_ctrl #(
  parameter int ADDR_WIDTH          = 32,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  parameter int NUM_BUFFERS         = 3,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] FB_STRIDE    = ADDR_WIDTH'(32'h0010_0000)
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic                           swap_req_valid,
  output logic                           swap_req_ready,
  input  logic                           swap_req_vsync,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0] swap_req_size,
  output logic [ADDR_WIDTH-1:0]          render_fb_addr,
  output logic                           swap_fb,
  output logic                           swap_fb_enable_vsync,
  output logic [ADDR_WIDTH-1:0]          fb_addr,
  output logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
  input  logic                           fb_swapped,
  output logic                           swap_timeout,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = (NUM_BUFFERS > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUFFERS - 1);
  localparam logic [IDX_W:0]   NUM_W    = (IDX_W + 1)'(NUM_BUFFERS);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  // Request handshake: a request is accepted on a rising edge where
  // swap_req_valid and swap_req_ready are both high; render_fb_addr is only
  // meaningful while swap_req_ready is high.
  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 disp_idx, q, rend_idx, next_disp;
  logic [IDX_W:0]                   rend_sum;
  logic                             accept, complete;
  logic                             vsync_mem [NUM_BUFFERS];
  logic [FB_SIZE_IN_PIXEL_LG-1:0]   size_mem  [NUM_BUFFERS];

  function automatic logic [ADDR_WIDTH-1:0] buf_addr(input logic [IDX_W-1:0] idx);
    return FB_BASE_ADDR + ADDR_WIDTH'(idx) * FB_STRIDE;
  endfunction

  // rend_sum never exceeds 2*NUM_BUFFERS-1, so one conditional subtract is a full modulo.
  assign rend_sum       = {1'b0, disp_idx} + {1'b0, q} + (IDX_W + 1)'(1);
  assign rend_idx       = (rend_sum >= NUM_W) ? IDX_W'(rend_sum - NUM_W) : rend_sum[IDX_W-1:0];
  assign next_disp      = (disp_idx == LAST_IDX) ? '0 : disp_idx + 1'b1;
  assign swap_req_ready = (q < LAST_IDX);
  assign accept         = swap_req_valid && swap_req_ready;
  assign render_fb_addr = buf_addr(rend_idx);
  assign dbg_state      = state_q;

`ifdef RIX_FB_SWAP_WATCHDOG_EN
  logic [23:0] wd_cnt;
  logic        wd_fire;

  assign wd_fire  = (state_q == WAIT) && (wd_cnt == 24'hFF_FFFF);
  assign complete = (state_q == WAIT) && (fb_swapped || wd_fire);

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      swap_timeout <= 1'b0;
    end else begin
      if ((state_q == WAIT) && !complete) wd_cnt <= wd_cnt + 24'd1;
      else                                wd_cnt <= '0;
      if (wd_fire && !fb_swapped) swap_timeout <= 1'b1;
    end
  end
`else
  assign complete     = (state_q == WAIT) && fb_swapped;
  assign swap_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    swap_fb = 1'b0;
    case (state_q)
      IDLE:  if (q != '0) state_d = ISSUE;
      ISSUE: begin
        swap_fb = 1'b1;
        state_d = WAIT;
      end
      WAIT:  if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      disp_idx <= '0;
      q        <= '0;
    end else begin
      if (complete) disp_idx <= next_disp;
      case ({accept, complete})
        2'b10:   q <= q + 1'b1;
        2'b01:   q <= q - 1'b1;
        default: q <= q;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        vsync_mem[i] <= 1'b0;
        size_mem[i]  <= '0;
      end
    end else if (accept) begin
      vsync_mem[rend_idx] <= swap_req_vsync;
      size_mem[rend_idx]  <= swap_req_size;
    end
  end

  // Display-side fields are captured as ISSUE is entered and held until the next ISSUE.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      fb_addr              <= FB_BASE_ADDR;
      fb_size              <= '0;
      swap_fb_enable_vsync <= 1'b0;
    end else if ((state_q == IDLE) && (state_d == ISSUE)) begin
      fb_addr              <= buf_addr(next_disp);
      fb_size              <= size_mem[next_disp];
      swap_fb_enable_vsync <= vsync_mem[next_disp];
    end
  end

endmodule

// File: tb/tb_rix_fb_swap_ctrl.sv
// Bench for rix_fb_swap_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rix_fb_swap_ctrl;
  localparam int          N      = 3;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] STRIDE = 32'h0010_0000;

  logic        clk, rst;
  logic        swap_req_valid, swap_req_ready, swap_req_vsync;
  logic [19:0] swap_req_size, fb_size;
  logic [31:0] render_fb_addr, fb_addr;
  logic        swap_fb, swap_fb_enable_vsync, fb_swapped, swap_timeout;
  logic [1:0]  dbg_state;

  logic        valid2, ready2, vsync2, swap_fb2, en_vsync2, swapped2, timeout2;
  logic [19:0] size2, fb_size2;
  logic [31:0] render2, fb_addr2;
  logic [1:0]  dbg_state2;

  rix_fb_swap_ctrl #(.NUM_BUFFERS(N), .FB_BASE_ADDR(BASE), .FB_STRIDE(STRIDE)) u_dut (
    .aclk(clk), .reset(rst),
    .swap_req_valid(swap_req_valid), .swap_req_ready(swap_req_ready),
    .swap_req_vsync(swap_req_vsync), .swap_req_size(swap_req_size),
    .render_fb_addr(render_fb_addr), .swap_fb(swap_fb),
    .swap_fb_enable_vsync(swap_fb_enable_vsync), .fb_addr(fb_addr), .fb_size(fb_size),
    .fb_swapped(fb_swapped), .swap_timeout(swap_timeout), .dbg_state(dbg_state)
  );

  rix_fb_swap_ctrl #(.NUM_BUFFERS(2), .FB_BASE_ADDR(BASE), .FB_STRIDE(STRIDE)) u_dut2 (
    .aclk(clk), .reset(rst),
    .swap_req_valid(valid2), .swap_req_ready(ready2),
    .swap_req_vsync(vsync2), .swap_req_size(size2),
    .render_fb_addr(render2), .swap_fb(swap_fb2),
    .swap_fb_enable_vsync(en_vsync2), .fb_addr(fb_addr2), .fb_size(fb_size2),
    .fb_swapped(swapped2), .swap_timeout(timeout2), .dbg_state(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses, pulses2;

  // Reference model: pending swaps as {vsync, size}, displayed index, handshake phase.
  logic [20:0] exp_q[$];
  int          m_disp, m_phase;  // phase: 0 waiting for work, 1 pulse cycle, 2 awaiting display
  logic [31:0] m_addr;
  logic [19:0] m_size;
  logic        m_vs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    return BASE + 32'(i) * STRIDE;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_disp  = 0;
    m_phase = 0;
    m_addr  = BASE;
    m_size  = '0;
    m_vs    = 1'b0;
  endtask

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = (exp_q.size() < N - 1);
    check("ready", swap_req_ready, exp_ready);
    if (exp_ready) check("render_addr", render_fb_addr, addr_of((m_disp + 1 + exp_q.size()) % N));
    check("swap_fb", swap_fb, m_phase == 1);
    check("fb_addr", fb_addr, m_addr);
    check("fb_size", fb_size, m_size);
    check("fb_vsync", swap_fb_enable_vsync, m_vs);
    check("timeout", swap_timeout, 1'b0);
    if (swap_fb) pulses++;
  endtask

  task automatic model_edge();
    logic acc;
    if (rst) begin
      model_reset();
    end else begin
      acc = swap_req_valid && (exp_q.size() < N - 1);
      if (m_phase == 2) begin
        if (fb_swapped) begin
          void'(exp_q.pop_front());
          m_disp  = (m_disp + 1) % N;
          m_phase = 0;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (exp_q.size() > 0) begin
        m_phase = 1;
        m_addr  = addr_of((m_disp + 1) % N);
        {m_vs, m_size} = exp_q[0];
      end
      if (acc) exp_q.push_back({swap_req_vsync, swap_req_size});
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    if (swap_fb2) pulses2++;
  endtask

  task automatic assert_reset(input int cycles);
    rst = 1'b1;
    model_reset();
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    swap_req_valid = 1'b0; swap_req_vsync = 1'b0; swap_req_size = '0; fb_swapped = 1'b0;
    valid2 = 1'b0; vsync2 = 1'b0; size2 = '0; swapped2 = 1'b0;
    pulses = 0; pulses2 = 0;
    #1;
    assert_reset(2);

    // Reset values
    check("rst_ready", swap_req_ready, 1'b1);
    check("rst_render", render_fb_addr, BASE + STRIDE);
    check("rst_swap_fb", swap_fb, 1'b0);
    check("rst_fb_addr", fb_addr, BASE);
    check("rst2_render", render2, BASE + STRIDE);
    step();

    // Single request, display acknowledges five cycles after acceptance
    pulses = 0;
    swap_req_valid = 1'b1; swap_req_vsync = 1'b1; swap_req_size = 20'd76800;
    step();
    swap_req_valid = 1'b0;
    repeat (4) step();
    fb_swapped = 1'b1;
    step();
    fb_swapped = 1'b0;
    step();
    step();
    check("single_pulses", pulses, 1);
    check("single_fb_addr", fb_addr, BASE + STRIDE);
    check("single_fb_size", fb_size, 20'd76800);
    check("single_vsync", swap_fb_enable_vsync, 1'b1);
    check("single_render", render_fb_addr, BASE + 2 * STRIDE);

    // Two-buffer ring: second request waits for the display acknowledge
    pulses2 = 0;
    valid2 = 1'b1; vsync2 = 1'b0; size2 = 20'd123;
    check("n2_ready_first", ready2, 1'b1);
    step();
    check("n2_ready_after_acc", ready2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("n2_ready_held_low", ready2, 1'b0);
    end
    check("n2_pulses_first", pulses2, 1);
    swapped2 = 1'b1;
    step();
    swapped2 = 1'b0;
    check("n2_ready_after_swap", ready2, 1'b1);
    step();
    check("n2_ready_second_acc", ready2, 1'b0);
    valid2 = 1'b0;
    repeat (3) step();
    check("n2_pulses_total", pulses2, 2);
    check("n2_fb_addr", fb_addr2, BASE);
    check("n2_fb_size", fb_size2, 20'd123);
    swapped2 = 1'b1;
    step();
    swapped2 = 1'b0;

    // Randomized traffic, covers wrap-around and same-edge accept/complete
    for (int i = 0; i < 1500; i++) begin
      swap_req_valid = ($urandom_range(0, 9) < 6);
      swap_req_vsync = 1'($urandom_range(0, 1));
      swap_req_size  = 20'($urandom_range(0, 20'hF_FFFF));
      fb_swapped     = ($urandom_range(0, 3) == 0);
      step();
    end

    // Reset while waiting on the display with two swaps queued
    swap_req_valid = 1'b0; fb_swapped = 1'b0;
    assert_reset(1);
    step();
    swap_req_valid = 1'b1; swap_req_vsync = 1'b1; swap_req_size = 20'd640;
    step();
    step();
    swap_req_valid = 1'b0;
    repeat (3) step();
    check("pre_rst_ready", swap_req_ready, 1'b0);
    pulses = 0;
    assert_reset(2);
    check("mid_rst_fb_addr", fb_addr, BASE);
    for (int i = 0; i < 10; i++) begin
      fb_swapped = 1'($urandom_range(0, 1));
      step();
    end
    fb_swapped = 1'b0;
    check("post_rst_pulses", pulses, 0);
    check("post_rst_ready", swap_req_ready, 1'b1);
    check("post_rst_render", render_fb_addr, BASE + STRIDE);
    check("post_rst_fb_size", fb_size, 20'd0);
    check("post_rst_vsync", swap_fb_enable_vsync, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
